// File: rtl/mgr_stack_down_pkt_arbiter_if.sv
// Downstream packet bus between the manager requesters and the stack-bus
// downstream channel. The arbiter uses the master view; the requester array
// and stack-bus side use the slave view.
interface mgr_stack_down_pkt_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 64,
  parameter int TYPE_W  = 2,
  parameter int OOB_W   = 32
);
  logic [NUM_REQ-1:0]        req__arb__valid;
  logic [2*NUM_REQ-1:0]      req__arb__cntl;
  logic [TYPE_W*NUM_REQ-1:0] req__arb__type;
  logic [DATA_W*NUM_REQ-1:0] req__arb__data;
  logic [OOB_W*NUM_REQ-1:0]  req__arb__oob;
  logic [NUM_REQ-1:0]        arb__req__ready;

  logic                      arb__std__valid;
  logic [1:0]                arb__std__cntl;
  logic [TYPE_W-1:0]         arb__std__type;
  logic [DATA_W-1:0]         arb__std__data;
  logic [OOB_W-1:0]          arb__std__oob;
  logic [ID_W-1:0]           arb__std__srcId;
  logic                      std__arb__ready;

  modport master (
    input  req__arb__valid, req__arb__cntl, req__arb__type, req__arb__data, req__arb__oob,
    output arb__req__ready,
    output arb__std__valid, arb__std__cntl, arb__std__type, arb__std__data, arb__std__oob,
    output arb__std__srcId,
    input  std__arb__ready
  );

  modport slave (
    output req__arb__valid, req__arb__cntl, req__arb__type, req__arb__data, req__arb__oob,
    input  arb__req__ready,
    input  arb__std__valid, arb__std__cntl, arb__std__type, arb__std__data, arb__std__oob,
    input  arb__std__srcId,
    output std__arb__ready
  );
endinterface

// File: rtl/mgr_stack_down_pkt_arbiter.sv
// Round-robin packet arbiter: shares one stack-bus downstream channel among
// NUM_REQ manager requesters, granting whole SOM..EOM packets, tagging each
// beat with its source ID, through one registered output stage.
module mgr_stack_down_pkt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 64,
  parameter int TYPE_W  = 2,
  parameter int OOB_W   = 32
) (
  input  logic                          clk,
  input  logic                          reset_poweron,
  mgr_stack_down_pkt_arbiter_if.master  bus,
  output logic [7:0]                    arb__sys__errCnt
);

  localparam logic [1:0] CNTL_MOM = 2'b00;
  localparam logic [1:0] CNTL_SOM = 2'b01;
  localparam logic [1:0] CNTL_EOM = 2'b10;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_PKT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [7:0]        err_cnt_q;

  logic [1:0]        cntl_a [NUM_REQ];
  logic [TYPE_W-1:0] type_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];
  logic [OOB_W-1:0]  oob_a  [NUM_REQ];

  logic              som_hit, drop_hit;
  logic [ID_W-1:0]   som_idx, drop_idx, cand;

  logic              slot_free;
  logic [NUM_REQ-1:0] ready_int;
  logic [ID_W-1:0]   sel_idx;
  logic              sel_vld, drop_en, err_inc;

  logic              vld_p0;
  logic [1:0]        cntl_p0;

  logic              vld_p1;
  logic [1:0]        cntl_p1;
  logic [TYPE_W-1:0] type_p1;
  logic [DATA_W-1:0] data_p1;
  logic [OOB_W-1:0]  oob_p1;
  logic [ID_W-1:0]   src_p1;

  // Saturating 8-bit increment for the malformed-beat counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Unpack the flat per-requester buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cntl_a[i] = bus.req__arb__cntl[2*i +: 2];
      type_a[i] = bus.req__arb__type[TYPE_W*i +: TYPE_W];
      data_a[i] = bus.req__arb__data[DATA_W*i +: DATA_W];
      oob_a[i]  = bus.req__arb__oob[OOB_W*i +: OOB_W];
    end
  end

  // Circular search from ptr for a valid packet start (SOM or SOM_EOM, both have cntl[0]=1).
  always_comb begin
    som_hit = 1'b0;
    som_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + ID_W'(k);
      if (!som_hit && bus.req__arb__valid[cand] && cntl_a[cand][0]) begin
        som_hit = 1'b1;
        som_idx = cand;
      end
    end
  end

  // Lowest-index valid MOM/EOM, the candidate for dropping while idle.
  always_comb begin
    drop_hit = 1'b0;
    drop_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!drop_hit && bus.req__arb__valid[i] && !cntl_a[i][0]) begin
        drop_hit = 1'b1;
        drop_idx = ID_W'(i);
      end
    end
  end

  assign slot_free = !vld_p1 || bus.std__arb__ready;

  // FSM state register with grant pointer, locked grant and error counter.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      if (err_inc) err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  // FSM next state: a SOM locks the grant, an EOM from the granted requester releases it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (vld_p0) begin
          if (cntl_p0 == CNTL_SOM) begin
            state_d = S_PKT;
            grant_d = sel_idx;
          end else begin
            ptr_d = sel_idx + ID_W'(1);
          end
        end
      end
      S_PKT: begin
        if (vld_p0 && cntl_p0 == CNTL_EOM) begin
          state_d = S_IDLE;
          ptr_d   = grant_q + ID_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: requester selection, per-requester ready, accepted beat and error event.
  always_comb begin
    ready_int = '0;
    sel_idx   = som_idx;
    sel_vld   = 1'b0;
    drop_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (som_hit) begin
          sel_idx            = som_idx;
          sel_vld            = 1'b1;
          ready_int[som_idx] = slot_free;
        end else if (drop_hit) begin
          drop_en             = 1'b1;
          ready_int[drop_idx] = 1'b1;
        end
      end
      S_PKT: begin
        sel_idx            = grant_q;
        sel_vld            = 1'b1;
        ready_int[grant_q] = slot_free;
      end
      default: ;
    endcase
    vld_p0  = sel_vld && slot_free && bus.req__arb__valid[sel_idx];
    cntl_p0 = cntl_a[sel_idx];
    err_inc = drop_en || (state_q == S_PKT && vld_p0 && cntl_p0[0]);
  end

  assign bus.arb__req__ready = reset_poweron ? '0 : ready_int;

  // Output stage: load on free slot, otherwise hold the beat under backpressure.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      vld_p1  <= 1'b0;
      cntl_p1 <= CNTL_MOM;
      type_p1 <= '0;
      data_p1 <= '0;
      oob_p1  <= '0;
      src_p1  <= '0;
    end else if (slot_free) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        cntl_p1 <= cntl_p0;
        type_p1 <= type_a[sel_idx];
        data_p1 <= data_a[sel_idx];
        oob_p1  <= oob_a[sel_idx];
        src_p1  <= sel_idx;
      end
    end
  end

  assign bus.arb__std__valid = vld_p1;
  assign bus.arb__std__cntl  = cntl_p1;
  assign bus.arb__std__type  = type_p1;
  assign bus.arb__std__data  = data_p1;
  assign bus.arb__std__oob   = oob_p1;
  assign bus.arb__std__srcId = src_p1;
  assign arb__sys__errCnt    = err_cnt_q;

endmodule

// File: tb/tb_mgr_stack_down_pkt_arbiter.sv
// Scoreboard bench for the downstream packet arbiter: per-requester beat
// queues feed the inputs, expected output beats are queued by each scenario.
module tb_mgr_stack_down_pkt_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 64;
  localparam int TYPE_W  = 2;
  localparam int OOB_W   = 32;

  localparam logic [1:0] MOM = 2'b00;
  localparam logic [1:0] SOM = 2'b01;
  localparam logic [1:0] EOM = 2'b10;
  localparam logic [1:0] SE  = 2'b11;

  typedef struct packed {
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [63:0] data;
    logic [31:0] oob;
    logic        bub;
  } beat_t;

  typedef struct packed {
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [63:0] data;
    logic [31:0] oob;
    logic [1:0]  src;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_poweron;
  logic [7:0] err_cnt;

  int    checks = 0;
  int    errors = 0;
  int    out_cnt = 0;
  beat_t src_q [NUM_REQ][$];
  exp_t  sb_q[$];
  logic  bub_drv [NUM_REQ];

  always #5 clk = ~clk;

  mgr_stack_down_pkt_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W), .OOB_W(OOB_W)
  ) bus ();

  mgr_stack_down_pkt_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W), .OOB_W(OOB_W)
  ) dut (
    .clk              (clk),
    .reset_poweron    (reset_poweron),
    .bus              (bus),
    .arb__sys__errCnt (err_cnt)
  );

  task automatic push_src(input int r, input logic [1:0] c, input logic [63:0] d);
    beat_t b;
    b.cntl = c; b.typ = d[1:0]; b.data = d; b.oob = {16'hC0DE, d[15:0]}; b.bub = 1'b0;
    src_q[r].push_back(b);
  endtask

  task automatic push_bub(input int r);
    beat_t b;
    b = '0; b.bub = 1'b1;
    src_q[r].push_back(b);
  endtask

  task automatic push_exp(input int r, input logic [1:0] c, input logic [63:0] d);
    exp_t e;
    e.cntl = c; e.typ = d[1:0]; e.data = d; e.oob = {16'hC0DE, d[15:0]}; e.src = 2'(r);
    sb_q.push_back(e);
  endtask

  // Requester drivers plus output monitor: sample at negedge, drive 1 after posedge.
  task automatic bfm_loop();
    logic  pop_f [NUM_REQ];
    exp_t  e, g;
    beat_t b;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++)
        pop_f[i] = (bus.req__arb__valid[i] && bus.arb__req__ready[i]) || bub_drv[i];
      if (bus.arb__std__valid && bus.std__arb__ready) begin
        out_cnt++;
        g.cntl = bus.arb__std__cntl; g.typ = bus.arb__std__type; g.data = bus.arb__std__data;
        g.oob = bus.arb__std__oob; g.src = bus.arb__std__srcId;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got cntl=%b data=%h src=%0d required no beat", g.cntl, g.data, g.src);
        end else begin
          e = sb_q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL out_beat got cntl=%b type=%b data=%h oob=%h src=%0d required cntl=%b type=%b data=%h oob=%h src=%0d",
                     g.cntl, g.typ, g.data, g.oob, g.src, e.cntl, e.typ, e.data, e.oob, e.src);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pop_f[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        bub_drv[i] = 1'b0;
        if (src_q[i].size() > 0) begin
          b = src_q[i][0];
          bus.req__arb__valid[i]               = !b.bub;
          bub_drv[i]                           = b.bub;
          bus.req__arb__cntl[2*i +: 2]         = b.cntl;
          bus.req__arb__type[TYPE_W*i +: TYPE_W] = b.typ;
          bus.req__arb__data[DATA_W*i +: DATA_W] = b.data;
          bus.req__arb__oob[OOB_W*i +: OOB_W]    = b.oob;
        end else begin
          bus.req__arb__valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    int pend;
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      pend = sb_q.size();
      for (int i = 0; i < NUM_REQ; i++) pend += src_q[i].size();
      if (pend == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_poweron = 1'b1;
    bus.std__arb__ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_poweron = 1'b0;
    bus.std__arb__ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus.arb__std__valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", bus.arb__std__valid); end
    checks++; if (bus.arb__std__cntl !== 2'b00) begin errors++; $display("FAIL reset_cntl got %b required 00", bus.arb__std__cntl); end
    checks++; if (bus.arb__std__type !== 2'b00) begin errors++; $display("FAIL reset_type got %b required 00", bus.arb__std__type); end
    checks++; if (bus.arb__std__data !== 64'h0) begin errors++; $display("FAIL reset_data got %h required 0", bus.arb__std__data); end
    checks++; if (bus.arb__std__oob !== 32'h0) begin errors++; $display("FAIL reset_oob got %h required 0", bus.arb__std__oob); end
    checks++; if (bus.arb__std__srcId !== 2'd0) begin errors++; $display("FAIL reset_srcid got %0d required 0", bus.arb__std__srcId); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d required 0", err_cnt); end
    checks++; if (bus.arb__req__ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b required 0000", bus.arb__req__ready); end
  endtask

  task automatic test_single();
    int acc_c, out_c, out_last, vcount;
    bit ok;
    do_reset();
    acc_c = -1; out_c = -1; out_last = -1; vcount = 0;
    push_src(0, SOM, 64'hA0); push_src(0, MOM, 64'hA1); push_src(0, EOM, 64'hA2);
    push_exp(0, SOM, 64'hA0); push_exp(0, MOM, 64'hA1); push_exp(0, EOM, 64'hA2);
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (acc_c < 0 && bus.req__arb__valid[0] && bus.arb__req__ready[0]) acc_c = n;
      if (bus.arb__std__valid) begin
        if (out_c < 0) out_c = n;
        out_last = n;
        vcount++;
      end
    end
    checks++;
    if (acc_c < 0 || out_c != acc_c + 1) begin
      errors++; $display("FAIL single_latency got accept=%0d first_out=%0d required first_out=accept+1", acc_c, out_c);
    end
    checks++;
    if (vcount != 3 || out_last - out_c != 2) begin
      errors++; $display("FAIL single_throughput got %0d valid cycles span %0d required 3 consecutive", vcount, out_last - out_c);
    end
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain got pending required none"); end
  endtask

  task automatic test_all4();
    bit ok;
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) begin
      push_src(r, SOM, 64'(16 * r + 1));
      push_src(r, EOM, 64'(16 * r + 2));
    end
    push_src(0, SOM, 64'h0B1); push_src(0, EOM, 64'h0B2);
    for (int r = 0; r < NUM_REQ; r++) begin
      push_exp(r, SOM, 64'(16 * r + 1));
      push_exp(r, EOM, 64'(16 * r + 2));
    end
    push_exp(0, SOM, 64'h0B1); push_exp(0, EOM, 64'h0B2);
    wait_idle(80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL all4_drain got %0d expected beats left required 0", sb_q.size()); end
  endtask

  task automatic test_backpressure();
    int base, n;
    logic [63:0] held;
    bit ok;
    do_reset();
    base = out_cnt;
    push_src(1, SOM, 64'h10); push_src(1, MOM, 64'h11); push_src(1, MOM, 64'h12);
    push_src(1, MOM, 64'h13); push_src(1, EOM, 64'h14);
    push_exp(1, SOM, 64'h10); push_exp(1, MOM, 64'h11); push_exp(1, MOM, 64'h12);
    push_exp(1, MOM, 64'h13); push_exp(1, EOM, 64'h14);
    n = 0;
    while (out_cnt < base + 2 && n < 40) begin
      @(posedge clk); #2; n++;
    end
    checks++; if (out_cnt < base + 2) begin errors++; $display("FAIL bp_start got %0d beats required 2", out_cnt - base); end
    bus.std__arb__ready = 1'b0;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) held = bus.arb__std__data;
      else begin
        checks++;
        if (bus.arb__std__data !== held) begin errors++; $display("FAIL bp_hold got %h required %h", bus.arb__std__data, held); end
      end
      checks++;
      if (bus.arb__std__valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b required 1", bus.arb__std__valid); end
      checks++;
      if (bus.arb__req__ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready got %b required 0", bus.arb__req__ready[1]); end
    end
    @(posedge clk); #2;
    bus.std__arb__ready = 1'b1;
    wait_idle(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain got %0d expected beats left required 0", sb_q.size()); end
  endtask

  task automatic test_mid_som();
    bit ok;
    do_reset();
    push_src(1, SOM, 64'h50); push_src(1, SOM, 64'h51); push_src(1, EOM, 64'h52);
    push_exp(1, SOM, 64'h50); push_exp(1, SOM, 64'h51); push_exp(1, EOM, 64'h52);
    wait_idle(30, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL midsom_drain got pending required none"); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL midsom_errcnt got %0d required 1", err_cnt); end
  endtask

  task automatic test_drop();
    bit ok;
    do_reset();
    push_src(2, MOM, 64'h77);
    wait_idle(20, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL drop_accept got pending required accepted"); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL drop_errcnt1 got %0d required 1", err_cnt); end
    checks++; if (bus.arb__std__valid !== 1'b0) begin errors++; $display("FAIL drop_novalid got %b required 0", bus.arb__std__valid); end
    for (int k = 0; k < 299; k++) push_src(2, (k % 2 == 1) ? EOM : MOM, 64'(k));
    wait_idle(400, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL drop_drain got pending required none"); end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL drop_errsat got %0d required 255", err_cnt); end
  endtask

  task automatic test_bubble();
    int n;
    bit ok;
    do_reset();
    @(negedge clk);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL bub_errcnt_reset got %0d required 0", err_cnt); end
    push_src(0, SOM, 64'h60); push_src(0, MOM, 64'h61); push_bub(0); push_bub(0);
    push_src(0, MOM, 64'h62); push_src(0, EOM, 64'h63);
    push_exp(0, SOM, 64'h60); push_exp(0, MOM, 64'h61); push_exp(0, MOM, 64'h62);
    push_exp(0, EOM, 64'h63); push_exp(1, SE, 64'h65);
    n = 0;
    while (src_q[0].size() > 5 && n < 30) begin
      @(posedge clk); #2; n++;
    end
    push_src(1, SE, 64'h65);
    n = 0;
    while (src_q[0].size() > 0 && n < 30) begin
      @(negedge clk); n++;
      if (bus.req__arb__valid[1] && src_q[0].size() > 0) begin
        checks++;
        if (bus.arb__req__ready[1] !== 1'b0) begin errors++; $display("FAIL bub_block got %b required 0", bus.arb__req__ready[1]); end
      end
    end
    wait_idle(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bub_drain got %0d expected beats left required 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    int base, n;
    bit ok;
    do_reset();
    push_src(2, SE, 64'h2E); push_exp(2, SE, 64'h2E);
    wait_idle(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_pre got pending required none"); end
    base = out_cnt;
    push_src(3, SOM, 64'h30); push_src(3, MOM, 64'h31); push_src(3, MOM, 64'h32);
    push_src(3, MOM, 64'h33); push_src(3, EOM, 64'h34);
    push_exp(3, SOM, 64'h30); push_exp(3, MOM, 64'h31);
    n = 0;
    while (out_cnt < base + 2 && n < 40) begin
      @(posedge clk); #2; n++;
    end
    reset_poweron = 1'b1;
    bus.std__arb__ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.arb__std__valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b required 0", bus.arb__std__valid); end
    checks++;
    if ({bus.arb__std__cntl, bus.arb__std__type, bus.arb__std__srcId} !== 6'd0) begin
      errors++; $display("FAIL rmid_ctl got %b required 000000", {bus.arb__std__cntl, bus.arb__std__type, bus.arb__std__srcId});
    end
    checks++;
    if ({bus.arb__std__data, bus.arb__std__oob} !== 96'd0) begin
      errors++; $display("FAIL rmid_data got %h required 0", {bus.arb__std__data, bus.arb__std__oob});
    end
    checks++; if (bus.arb__req__ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready got %b required 0000", bus.arb__req__ready); end
    @(posedge clk); #2;
    reset_poweron = 1'b0;
    bus.std__arb__ready = 1'b1;
    push_src(3, SE, 64'h3F); push_src(0, SE, 64'h0F);
    push_exp(0, SE, 64'h0F); push_exp(3, SE, 64'h3F);
    wait_idle(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_drain got %0d expected beats left required 0", sb_q.size()); end
  endtask

  initial begin
    reset_poweron       = 1'b1;
    bus.std__arb__ready = 1'b0;
    bus.req__arb__valid = '0;
    bus.req__arb__cntl  = '0;
    bus.req__arb__type  = '0;
    bus.req__arb__data  = '0;
    bus.req__arb__oob   = '0;
    for (int i = 0; i < NUM_REQ; i++) bub_drv[i] = 1'b0;
    fork
      bfm_loop();
    join_none
    test_reset();
    test_single();
    test_all4();
    test_backpressure();
    test_mid_som();
    test_drop();
    test_bubble();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
